// File: rtl/apb_master.sv
// APB initiator: accepts single read/write commands over valid/ready, runs one APB transfer
// each and returns a one-cycle response strobe. Define APB_MASTER_TIMEOUT_EN for the ACCESS watchdog.
module apb_master #(
    parameter int APB_BUS_SIZE   = 32,
    parameter int ADDR_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_SIZE-1:0]    cmd_addr,
    input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [APB_BUS_SIZE-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_SIZE-1:0]    paddr,
    output logic [APB_BUS_SIZE-1:0] pwdata,
    input  logic [APB_BUS_SIZE-1:0] prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic                    cmd_accept_s;
    logic                    xfer_done_s;
    logic                    xfer_abort_s;
    logic                    wd_expired_s;

    logic                    cmd_ready_r,   cmd_ready_s;
    logic                    psel_r,        psel_s;
    logic                    penable_r,     penable_s;
    logic                    pwrite_r,      pwrite_s;
    logic [ADDR_SIZE-1:0]    paddr_r,       paddr_s;
    logic [APB_BUS_SIZE-1:0] pwdata_r,      pwdata_s;
    logic                    rsp_valid_r,   rsp_valid_s;
    logic [APB_BUS_SIZE-1:0] rsp_rdata_r,   rsp_rdata_s;
    logic                    rsp_err_r,     rsp_err_s;
    logic                    rsp_timeout_r, rsp_timeout_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and next values for every registered output
    always_comb begin
        next_state_s  = state_r;
        cmd_accept_s  = 1'b0;
        xfer_done_s   = 1'b0;
        xfer_abort_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    cmd_accept_s = 1'b1;
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                next_state_s = ACCESS;
            end
            ACCESS: begin
                // pready beats the watchdog when both land on the same cycle
                if (pready) begin
                    xfer_done_s  = 1'b1;
                    next_state_s = IDLE;
                end else if (wd_expired_s) begin
                    xfer_abort_s = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        cmd_ready_s = (next_state_s == IDLE);
        psel_s      = (next_state_s == SETUP) || (next_state_s == ACCESS);
        penable_s   = (next_state_s == ACCESS);

        if (cmd_accept_s) begin
            pwrite_s = cmd_write;
            paddr_s  = cmd_addr;
            pwdata_s = cmd_wdata;
        end else begin
            pwrite_s = pwrite_r;
            paddr_s  = paddr_r;
            pwdata_s = pwdata_r;
        end

        rsp_valid_s   = xfer_done_s || xfer_abort_s;
        rsp_err_s     = (xfer_done_s && pslverr) || xfer_abort_s;
        rsp_timeout_s = xfer_abort_s;
        if (xfer_done_s && !pwrite_r) begin
            rsp_rdata_s = prdata;
        end else begin
            rsp_rdata_s = '0;
        end
    end

    // APB and response output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_r   <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            cmd_ready_r   <= cmd_ready_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwrite_r      <= pwrite_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_err_r     <= rsp_err_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wait_cnt_r;

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (state_r == SETUP) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ACCESS) && !pready && !wd_expired_s) begin
            wait_cnt_r <= wait_cnt_r + WD_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The current ACCESS cycle is the last allowed wait state
    assign wd_expired_s = (wait_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog ACCESS never expires
    assign wd_expired_s = (TIMEOUT_CYCLES < 0);
`endif

    assign cmd_ready   = cmd_ready_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master: reset, writes, reads with wait states,
// slave error, queued commands, mid-transfer reset and the ACCESS watchdog.
module tb_apb_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks;
    int n_fail;

    apb_master #(
        .APB_BUS_SIZE  (32),
        .ADDR_SIZE     (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL rst_psel: got %b want 0", psel); end
        n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b want 0", penable); end
        n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
        n_checks++; if (paddr !== 8'h00) begin n_fail++; $display("FAIL rst_paddr: got %h want 00", paddr); end
        n_checks++; if (pwdata !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_timeout: got %b want 0", rsp_timeout); end
        rst = 1'b0;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 32'h0000_1013;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (psel !== 1'b1) begin n_fail++; $display("FAIL wr_setup_psel: got %b want 1", psel); end
        n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL wr_setup_penable: got %b want 0", penable); end
        n_checks++; if (pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_setup_pwrite: got %b want 1", pwrite); end
        n_checks++; if (pwdata !== 32'h0000_1013) begin n_fail++; $display("FAIL wr_setup_pwdata: got %h want 00001013", pwdata); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_setup_ready: got %b want 0", cmd_ready); end
        tick();
        n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL wr_access: got psel=%b penable=%b want 1/1", psel, penable); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_access_rsp: got %b want 0", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL wr_done_bus: got psel=%b penable=%b want 0/0", psel, penable); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_done_ready: got %b want 1", cmd_ready); end
        n_checks++; if (pwdata !== 32'h0000_1013 || pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_idle_hold: got pwdata=%h pwrite=%b want 00001013/1", pwdata, pwrite); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_strobe: got %b want 0", rsp_valid); end
    endtask

    task automatic test_read_wait_states();
        int penable_cycles;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h0C; cmd_wdata = 32'h1111_2222;
        pready = 1'b0; prdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (psel !== 1'b1 || pwrite !== 1'b0 || paddr !== 8'h0C) begin n_fail++; $display("FAIL rd_setup: got psel=%b pwrite=%b paddr=%h want 1/0/0c", psel, pwrite, paddr); end
        tick();
        penable_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (penable === 1'b1 && rsp_valid === 1'b0 && paddr === 8'h0C) penable_cycles++;
            if (i == 3) begin
                pready = 1'b1; prdata = 32'h00AB_CDEF;
            end
            tick();
        end
        n_checks++; if (penable_cycles !== 4) begin n_fail++; $display("FAIL rd_penable_len: got %0d want 4", penable_cycles); end
        n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL rd_penable_drop: got %b want 0", penable); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h want 00abcdef", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
        pready = 1'b0; prdata = 32'h5A5A_5A5A;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_rsp_clear: got valid=%b rdata=%h want 0/0", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_slverr();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h1234_5678;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL err_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_rsp_err: got %b want 1", rsp_err); end
        n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL err_rsp_timeout: got %b want 0", rsp_timeout); end
        n_checks++; if (rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL err_rsp_rdata: got %h want 12345678", rsp_rdata); end
        pslverr = 1'b0;
        tick();
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", rsp_err); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hA5A5_0001;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h55AA_0F0F;
        tick();
        cmd_write = 1'b0; cmd_addr = 8'h14; cmd_wdata = 32'h0;
        n_checks++; if (cmd_ready !== 1'b0 || paddr !== 8'h10) begin n_fail++; $display("FAIL b2b_setup1: got ready=%b paddr=%h want 0/10", cmd_ready, paddr); end
        tick();
        n_checks++; if (paddr !== 8'h10 || pwrite !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL b2b_access1: got paddr=%h pwrite=%b penable=%b want 10/1/1", paddr, pwrite, penable); end
        tick();
        n_checks++; if (psel !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got psel=%b ready=%b rsp_valid=%b want 0/1/1", psel, cmd_ready, rsp_valid); end
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 8'h14 || pwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_setup2: got psel=%b penable=%b paddr=%h pwrite=%b want 1/0/14/0", psel, penable, paddr, pwrite); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe1: got %b want 0", rsp_valid); end
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA_0F0F) begin n_fail++; $display("FAIL b2b_rsp2: got valid=%b rdata=%h want 1/55aa0f0f", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        int spurious;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
        pready = 1'b0; prdata = 32'h7777_7777;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL mid_access: got psel=%b penable=%b want 1/1", psel, penable); end
        rst = 1'b1;
        #1;
        n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async: got psel=%b penable=%b rsp_valid=%b want 0/0/0", psel, penable, rsp_valid); end
        n_checks++; if (paddr !== 8'h00 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_regs: got paddr=%h ready=%b want 00/0", paddr, cmd_ready); end
        pready = 1'b1;
        tick();
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || psel !== 1'b0) spurious++;
        end
        n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d bad cycles want 0", spurious); end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h24; cmd_wdata = 32'h0BAD_F00D;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_recover: got valid=%b err=%b rdata=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (pwdata !== 32'h0BAD_F00D || paddr !== 8'h24) begin n_fail++; $display("FAIL mid_recover_bus: got pwdata=%h paddr=%h want 0badf00d/24", pwdata, paddr); end
        tick();
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hEEEE_EEEE;
        tick();
        cmd_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (penable !== 1'b1 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL to_wait: got %0d bad cycles want 0", bad); end
        n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL to_abort_bus: got psel=%b penable=%b ready=%b want 0/0/1", psel, penable, cmd_ready); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_abort_rsp: got v=%b e=%b t=%b d=%h want 1/1/1/0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got v=%b t=%b want 0/0", rsp_valid, rsp_timeout); end
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                pready = 1'b1; prdata = 32'h0000_CAFE;
            end
            tick();
        end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL to_race: got v=%b e=%b t=%b d=%h want 1/0/0/0000cafe", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        pready = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hEEEE_EEEE;
        tick();
        cmd_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL nto_wait: got %0d bad cycles want 0", bad); end
        pready = 1'b1; prdata = 32'h0000_CAFE;
        tick();
        pready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL nto_done: got v=%b t=%b d=%h want 1/0/0000cafe", rsp_valid, rsp_timeout, rsp_rdata); end
        tick();
    endtask
`endif

    // Directed test sequence
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 32'h0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_slverr();
        test_back_to_back();
        test_reset_mid_transfer();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
